// File: rtl/lock_plant_model.sv
// Behavioural canal-lock chamber: water level, boat traffic and a sticky
// fault flag for illegal controller commands. All outputs are registered.
module lock_plant_model #(
  parameter int LOW_LVL   = 0,
  parameter int HIGH_LVL  = 40,
  parameter int FILL_DIV  = 4,
  parameter int DRAIN_DIV = 4,
  parameter int MOVE_CYC  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] gate_state,
  input  logic       boat_up,
  input  logic       boat_lo,
  output logic [5:0] water_level,
  output logic       upper_switch,
  output logic       lower_switch,
  output logic       arriving,
  output logic       departing,
  output logic       fault
);

  localparam int MAX_DIV = (FILL_DIV > DRAIN_DIV) ? FILL_DIV : DRAIN_DIV;
  localparam int RW      = $clog2(MAX_DIV + 1);
  localparam int MW      = $clog2(MOVE_CYC + 1);

  localparam logic [5:0]    LOW6      = 6'(LOW_LVL);
  localparam logic [5:0]    HIGH6     = 6'(HIGH_LVL);
  localparam logic [RW-1:0] FILL_LAST = RW'(FILL_DIV - 1);
  localparam logic [RW-1:0] DRN_LAST  = RW'(DRAIN_DIV - 1);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYC - 1);

  typedef enum logic [2:0] {
    GS_CLOSED = 3'b000,
    GS_FILL   = 3'b001,
    GS_DRAIN  = 3'b010,
    GS_UPPER  = 3'b011,
    GS_LOWER  = 3'b100
  } gate_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_UP,
    WAIT_LO,
    IN_LOCK
  } boat_state_t;

  gate_cmd_t     cmd;
  gate_cmd_t     prev_cmd;
  boat_state_t   state;
  logic          dir;
  logic [RW-1:0] rate_cnt;
  logic [RW-1:0] rate_eff;
  logic [MW-1:0] move_cnt;
  logic          illegal_code;
  logic          fault_hit;
  logic          upper_open;
  logic          lower_open;
  logic          move_gate;

  always_comb begin
    illegal_code = (gate_state > 3'd4);
    cmd          = illegal_code ? GS_CLOSED : gate_cmd_t'(gate_state);
    fault_hit    = illegal_code
                 || ((cmd == GS_UPPER) && (water_level != HIGH6))
                 || ((cmd == GS_LOWER) && (water_level != LOW6));
    upper_open   = (cmd == GS_UPPER) && !fault_hit;
    lower_open   = (cmd == GS_LOWER) && !fault_hit;
    // A direct fill<->drain switch restarts the rate count from zero this cycle.
    rate_eff     = (cmd == prev_cmd) ? rate_cnt : '0;
  end

  always_comb begin
    move_gate = 1'b0;
    case (state)
      WAIT_UP: move_gate = upper_open;
      WAIT_LO: move_gate = lower_open;
      IN_LOCK: move_gate = dir ? upper_open : lower_open;
      default: move_gate = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      water_level <= LOW6;
      rate_cnt    <= '0;
      prev_cmd    <= GS_CLOSED;
      fault       <= 1'b0;
    end else begin
      prev_cmd <= cmd;
      fault    <= fault | fault_hit;
      case (cmd)
        GS_FILL: begin
          if (rate_eff == FILL_LAST) begin
            rate_cnt <= '0;
            if (water_level < HIGH6)
              water_level <= water_level + 6'd1;
          end else begin
            rate_cnt <= rate_eff + 1'b1;
          end
        end
        GS_DRAIN: begin
          if (rate_eff == DRN_LAST) begin
            rate_cnt <= '0;
            if (water_level > LOW6)
              water_level <= water_level - 6'd1;
          end else begin
            rate_cnt <= rate_eff + 1'b1;
          end
        end
        default: rate_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dir          <= 1'b0;
      move_cnt     <= '0;
      upper_switch <= 1'b0;
      lower_switch <= 1'b0;
      arriving     <= 1'b0;
      departing    <= 1'b0;
    end else begin
      arriving  <= 1'b0;
      departing <= 1'b0;
      case (state)
        IDLE: begin
          move_cnt <= '0;
          if (boat_up) begin
            state        <= WAIT_UP;
            upper_switch <= 1'b1;
            dir          <= 1'b0;
          end else if (boat_lo) begin
            state        <= WAIT_LO;
            lower_switch <= 1'b1;
            dir          <= 1'b1;
          end
        end
        WAIT_UP, WAIT_LO, IN_LOCK: begin
          if (!move_gate) begin
            move_cnt <= '0;
          end else if (move_cnt != MOVE_LAST) begin
            move_cnt <= move_cnt + 1'b1;
          end else begin
            move_cnt <= '0;
            if (state == IN_LOCK) begin
              state     <= IDLE;
              departing <= 1'b1;
            end else begin
              state        <= IN_LOCK;
              arriving     <= 1'b1;
              upper_switch <= 1'b0;
              lower_switch <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_plant_model.sv
// Directed and randomized checks of lock_plant_model against a cycle-level
// reference model built from run lengths of identical commands.
module tb_lock_plant_model;

  localparam int LOW  = 0;
  localparam int HIGH = 40;
  localparam int FD   = 4;
  localparam int DD   = 4;
  localparam int MOVE = 8;

  logic       clk;
  logic       reset;
  logic [2:0] gate_state;
  logic       boat_up;
  logic       boat_lo;
  logic [5:0] water_level;
  logic       upper_switch;
  logic       lower_switch;
  logic       arriving;
  logic       departing;
  logic       fault;

  int n_cmp;
  int n_bad;

  // reference model state
  int m_level;
  int m_last_eff;
  int m_wrun;
  int m_fault;
  int m_side;      // 0 nobody waiting, 1 waiting upstream, 2 waiting downstream
  int m_inside;    // boat currently in the chamber
  int m_dir;       // 0 heading down, 1 heading up
  int m_pass;      // consecutive useful gate-open cycles
  int m_arr;
  int m_dep;

  lock_plant_model #(
    .LOW_LVL  (LOW),
    .HIGH_LVL (HIGH),
    .FILL_DIV (FD),
    .DRAIN_DIV(DD),
    .MOVE_CYC (MOVE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gate_state  (gate_state),
    .boat_up     (boat_up),
    .boat_lo     (boat_lo),
    .water_level (water_level),
    .upper_switch(upper_switch),
    .lower_switch(lower_switch),
    .arriving    (arriving),
    .departing   (departing),
    .fault       (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = LOW; m_last_eff = 0; m_wrun = 0; m_fault = 0;
    m_side = 0; m_inside = 0; m_dir = 0; m_pass = 0; m_arr = 0; m_dep = 0;
  endtask

  task automatic model_step(input int gs, input bit bu, input bit bl);
    int eff;
    bit bad, up_ok, lo_ok, useful;
    eff   = (gs > 4) ? 0 : gs;
    bad   = (gs > 4) || (gs == 3 && m_level != HIGH) || (gs == 4 && m_level != LOW);
    up_ok = (gs == 3) && !bad;
    lo_ok = (gs == 4) && !bad;
    if (eff == 1 || eff == 2) begin
      m_wrun = (eff == m_last_eff) ? m_wrun + 1 : 1;
      if (m_wrun % ((eff == 1) ? FD : DD) == 0) begin
        if (eff == 1 && m_level < HIGH) m_level++;
        if (eff == 2 && m_level > LOW)  m_level--;
      end
    end else begin
      m_wrun = 0;
    end
    m_last_eff = eff;
    if (bad) m_fault = 1;
    m_arr = 0;
    m_dep = 0;
    if (m_side == 0 && m_inside == 0) begin
      m_pass = 0;
      if (bu) begin m_side = 1; m_dir = 0; end
      else if (bl) begin m_side = 2; m_dir = 1; end
    end else begin
      if (m_inside != 0) useful = (m_dir != 0) ? up_ok : lo_ok;
      else               useful = (m_side == 1) ? up_ok : lo_ok;
      m_pass = useful ? m_pass + 1 : 0;
      if (m_pass == MOVE) begin
        m_pass = 0;
        if (m_inside != 0) begin m_inside = 0; m_dep = 1; end
        else begin m_side = 0; m_inside = 1; m_arr = 1; end
      end
    end
  endtask

  task automatic check_all();
    check("water_level",  water_level,  m_level);
    check("upper_switch", upper_switch, (m_side == 1) ? 1 : 0);
    check("lower_switch", lower_switch, (m_side == 2) ? 1 : 0);
    check("arriving",     arriving,     m_arr);
    check("departing",    departing,    m_dep);
    check("fault",        fault,        m_fault);
  endtask

  task automatic step(input logic [2:0] gs, input logic bu, input logic bl);
    gate_state = gs;
    boat_up    = bu;
    boat_lo    = bl;
    @(posedge clk);
    #1;
    model_step(int'(gs), bu, bl);
    check_all();
  endtask

  task automatic hold(input logic [2:0] gs, input int n);
    for (int i = 0; i < n; i++) step(gs, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    gate_state = 3'd0;
    boat_up    = 1'b0;
    boat_lo    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();

    // 1: fill cadence
    do_reset();
    hold(3'd1, 4);
    check("t1_lvl4", water_level, 1);
    hold(3'd1, 4);
    check("t1_lvl8", water_level, 2);
    hold(3'd1, 4);
    check("t1_lvl12", water_level, 3);

    // 2: saturation both ways
    hold(3'd1, 200);
    check("t2_high_sat", water_level, HIGH);
    hold(3'd2, 200);
    check("t2_low_sat", water_level, LOW);
    check("t2_no_fault", fault, 0);

    // 3: simultaneous arrivals, full down-bound passage
    do_reset();
    step(3'd0, 1'b1, 1'b1);
    check("t3_upper_sw", upper_switch, 1);
    check("t3_lower_sw", lower_switch, 0);
    hold(3'd1, 160);
    check("t3_full", water_level, HIGH);
    hold(3'd3, 7);
    check("t3_no_arr_yet", arriving, 0);
    hold(3'd3, 1);
    check("t3_arriving", arriving, 1);
    check("t3_upper_clr", upper_switch, 0);
    hold(3'd0, 1);
    check("t3_arr_pulse", arriving, 0);
    hold(3'd2, 160);
    check("t3_empty", water_level, LOW);
    hold(3'd4, 8);
    check("t3_departing", departing, 1);
    hold(3'd0, 1);
    check("t3_dep_pulse", departing, 0);
    step(3'd0, 1'b0, 1'b1);
    check("t3_idle_again", lower_switch, 1);

    // 4: interrupted gate run restarts the count
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    hold(3'd4, 5);
    hold(3'd0, 1);
    hold(3'd4, 7);
    check("t4_no_arr", arriving, 0);
    hold(3'd4, 1);
    check("t4_arriving", arriving, 1);
    check("t4_lower_clr", lower_switch, 0);
    hold(3'd1, 20);
    check("t4_lvl5", water_level, 5);
    do_reset();
    check("t6_rst_level", water_level, LOW);
    check("t6_rst_arr", arriving, 0);
    hold(3'd3, 8);
    check("t6_boat_gone", departing, 0);

    // 5: wrong-level gate open
    do_reset();
    hold(3'd1, 40);
    check("t5_lvl10", water_level, 10);
    hold(3'd3, 1);
    check("t5_fault", fault, 1);
    hold(3'd1, 5);
    hold(3'd0, 3);
    check("t5_sticky", fault, 1);
    do_reset();
    check("t5_cleared", fault, 0);

    // 6: illegal code during fill
    hold(3'd1, 2);
    hold(3'd6, 1);
    check("t6_fault", fault, 1);
    check("t6_hold", water_level, 0);
    hold(3'd1, 3);
    check("t6_cnt_clr", water_level, 0);
    hold(3'd1, 1);
    check("t6_step", water_level, 1);

    // randomized segments
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int s = 0; s < 30; s++) begin
        int pick, len;
        logic [2:0] gs;
        pick = $urandom_range(0, 99);
        if (pick < 30)      gs = 3'd1;
        else if (pick < 55) gs = 3'd2;
        else if (pick < 70) gs = 3'd3;
        else if (pick < 85) gs = 3'd4;
        else if (pick < 95) gs = 3'd0;
        else                gs = 3'($urandom_range(5, 7));
        len = $urandom_range(1, 50);
        for (int c = 0; c < len; c++) begin
          step(gs, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
          // occasional single-cycle command glitch to exercise switches
          if ($urandom_range(0, 30) == 0) step(3'($urandom_range(0, 4)), 1'b0, 1'b0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
